// File: rtl/uart_rx.sv
// Oversampling UART receiver: recovers one start/data/[parity]/stop frame per
// pass and strobes the byte out, or pulses a parity/framing error instead.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  parity_type,
    input  logic                  parity_enable,
    input  logic [5:0]            prescale,
    input  logic                  serial_data_in,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  parity_error,
    output logic                  frame_error
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DATA_VALID} state_t;

    state_t                state;
    logic [5:0]            edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [2:0]            smp;

    logic [5:0] half;
    logic [5:0] last_edge;
    logic       bit_end;
    logic       bit_val;

    assign half      = {1'b0, prescale[5:1]};
    assign last_edge = prescale - 6'd1;
    assign bit_end   = (edge_cnt == last_edge);
    // majority of the three mid-bit samples, settled from edge half+2 onward
    assign bit_val   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            smp           <= '0;
            data_valid    <= 1'b0;
            parallel_data <= '0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            edge_cnt     <= bit_end ? 6'd0 : edge_cnt + 6'd1;

            if (edge_cnt == half - 6'd1) smp[0] <= serial_data_in;
            if (edge_cnt == half)        smp[1] <= serial_data_in;
            if (edge_cnt == half + 6'd1) smp[2] <= serial_data_in;

            case (state)
                IDLE: begin
                    // the detecting cycle is edge 0, so the next one is edge 1
                    if (!serial_data_in) begin
                        state    <= START;
                        edge_cnt <= 6'd1;
                    end else begin
                        edge_cnt <= '0;
                    end
                end
                START: begin
                    if (edge_cnt == half + 6'd2 && bit_val) begin
                        frame_error <= 1'b1;
                        state       <= IDLE;
                        edge_cnt    <= '0;
                    end else if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt == BW'(DATA_WIDTH - 1))
                            state <= parity_enable ? PARITY : STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        if (bit_val != ((^shift_reg) ^ parity_type)) begin
                            parity_error <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!bit_val) begin
                            frame_error <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            data_valid    <= 1'b1;
                            parallel_data <= shift_reg;
                            state         <= DATA_VALID;
                        end
                    end
                end
                DATA_VALID: begin
                    if (!serial_data_in) begin
                        state    <= START;
                        edge_cnt <= 6'd1;
                    end else begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed frames for uart_rx; expected events go to a queue that a negedge
// monitor drains and compares whenever the receiver strobes an output.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       parity_type;
    logic       parity_enable;
    logic [5:0] prescale;
    logic       serial_data_in;
    logic       data_valid;
    logic [7:0] parallel_data;
    logic       parity_error;
    logic       frame_error;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .parity_type   (parity_type),
        .parity_enable (parity_enable),
        .prescale      (prescale),
        .serial_data_in(serial_data_in),
        .data_valid    (data_valid),
        .parallel_data (parallel_data),
        .parity_error  (parity_error),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] K_DV = 3'b001;
    localparam logic [2:0] K_PE = 3'b010;
    localparam logic [2:0] K_FE = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && (data_valid || parity_error || frame_error)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, frame_error, parity_error, data_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_kind", {29'd0, frame_error, parity_error, data_valid}, {29'd0, e.kind});
                if (e.kind == K_DV) check("sb_data", {24'd0, parallel_data}, {24'd0, e.data});
            end
        end
    end

    // every task call starts and ends 1 time unit after a rising edge
    task automatic drive_bit(input logic b);
        serial_data_in = b;
        repeat (prescale) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_data_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] d, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (parity_enable) drive_bit(par_bit);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit);
        send_body(d, par_bit);
        drive_bit(1'b1);
    endtask

    task automatic check_good(input string name, input logic [7:0] d);
        @(negedge clk);
        check({name, "_dv"}, {31'd0, data_valid}, 32'd1);
        check({name, "_data"}, {24'd0, parallel_data}, {24'd0, d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        serial_data_in = 1'b1;
        prescale       = 6'd8;
        parity_enable  = 1'b0;
        parity_type    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_pe", {31'd0, parity_error}, 32'd0);
        check("rst_fe", {31'd0, frame_error}, 32'd0);
        check("rst_data", {24'd0, parallel_data}, 32'd0);
        reset = 1'b0;
        idle(4);

        // even parity, 0x6A has four ones -> parity bit 0
        parity_enable = 1'b1;
        parity_type   = 1'b0;
        push(K_DV, 8'h6A);
        send_frame(8'h6A, 1'b0);
        check_good("even_6a", 8'h6A);
        idle(4);

        // no parity, two frames with 4 idle cycles between
        parity_enable = 1'b0;
        push(K_DV, 8'hA5);
        send_frame(8'hA5, 1'b0);
        check_good("np_a5", 8'hA5);
        idle(3);
        push(K_DV, 8'h5A);
        send_frame(8'h5A, 1'b0);
        check_good("np_5a", 8'h5A);
        idle(4);

        // odd parity, 0xF7 has seven ones -> parity bit 0
        parity_enable = 1'b1;
        parity_type   = 1'b1;
        push(K_DV, 8'hF7);
        send_frame(8'hF7, 1'b0);
        check_good("odd_f7", 8'hF7);
        idle(4);

        // one-cycle start glitch
        push(K_FE, 8'h00);
        serial_data_in = 1'b0;
        @(posedge clk);
        #1;
        serial_data_in = 1'b1;
        for (int i = 0; i < 40 && !frame_error; i++) @(negedge clk);
        check("glitch_fe", {31'd0, frame_error}, 32'd1);
        check("glitch_dv", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("glitch_fe_clear", {31'd0, frame_error}, 32'd0);
        @(posedge clk);
        #1;
        idle(4);

        // odd parity, 0x57 has five ones -> parity bit should be 0, send 1
        push(K_PE, 8'h00);
        send_body(8'h57, 1'b1);
        serial_data_in = 1'b1;
        @(negedge clk);
        check("par_pe", {31'd0, parity_error}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("par_pe_clear", {31'd0, parity_error}, 32'd0);
        check("par_data_held", {24'd0, parallel_data}, 32'h0000_00F7);
        @(posedge clk);
        #1;
        idle(8);

        // stop bit low
        parity_enable = 1'b0;
        push(K_FE, 8'h00);
        send_body(8'h88, 1'b0);
        drive_bit(1'b0);
        serial_data_in = 1'b1;
        @(negedge clk);
        check("stop_fe", {31'd0, frame_error}, 32'd1);
        check("stop_dv", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        check("stop_fe_clear", {31'd0, frame_error}, 32'd0);
        check("stop_data_held", {24'd0, parallel_data}, 32'h0000_00F7);
        @(posedge clk);
        #1;
        idle(8);

        // prescale 16
        prescale = 6'd16;
        push(K_DV, 8'h3C);
        send_frame(8'h3C, 1'b0);
        check_good("p16_3c", 8'h3C);
        idle(4);

        // reset in the middle of the data bits
        prescale = 6'd8;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b1;
        #1;
        check("midrst_dv", {31'd0, data_valid}, 32'd0);
        check("midrst_pe", {31'd0, parity_error}, 32'd0);
        check("midrst_fe", {31'd0, frame_error}, 32'd0);
        check("midrst_data", {24'd0, parallel_data}, 32'd0);
        serial_data_in = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        push(K_DV, 8'hC3);
        send_frame(8'hC3, 1'b0);
        check_good("after_rst_c3", 8'hC3);
        idle(8);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receive block: recovers one serial frame from `serial_data_in` and presents the data byte on `parallel_data` with a one-cycle `data_valid` strobe.
- Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity bit, stop(1).
- The receive clock runs at `prescale` × bit rate.
- Sits at the RX side of the system UART, feeding the command/register layer; reports parity and framing errors as one-cycle pulses.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  receive oversampling clock.
- reset  input  1  asynchronous, active-high reset.
- parity_type  input  1  0 = even parity, 1 = odd parity.
- parity_enable  input  1  1 = frame carries a parity bit.
- prescale  input  6  clock cycles per bit; legal values 8, 16, 32.
- serial_data_in  input  1  serial line, idle high.
- data_valid  output  1  one-cycle strobe: `parallel_data` holds a good frame.
- parallel_data  output  DATA_WIDTH  last correctly received byte.
- parity_error  output  1  one-cycle pulse on parity mismatch.
- frame_error  output  1  one-cycle pulse on bad start or stop bit.

Behaviour:
- Reset (any time, including mid-frame):
  - FSM goes to IDLE; edge and bit counters clear.
  - All outputs = 0, `parallel_data` = 0.
- Config inputs (`prescale`, `parity_enable`, `parity_type`) must be stable from start detection to frame end; they are not checked.
- States: IDLE, START, DATA, PARITY, STOP, DATA_VALID.
- Edge counter counts 0..prescale-1 within each bit; the bit counter advances when the edge counter wraps.
- IDLE:
  - `serial_data_in` = 0 at a clk rising edge → START. That cycle counts as edge 0 of the start bit.
- Sampling:
  - Take 3 samples at edge counts prescale/2-1, prescale/2, prescale/2+1.
  - Bit value = majority of the 3 samples, available from edge prescale/2+2.
- START:
  - Sampled value 1 (glitch) → pulse `frame_error` for 1 cycle, return to IDLE.
  - Otherwise, at edge prescale-1 → DATA.
- DATA:
  - Shift DATA_WIDTH bits LSB first into an internal register.
  - After the last bit's edge prescale-1 → PARITY if `parity_enable`, else → STOP.
- PARITY:
  - Expected bit = XOR of data (even, `parity_type` = 0), or XNOR of data (odd, `parity_type` = 1).
  - Mismatch → `parity_error` = 1 for exactly 1 cycle at edge prescale-1, then IDLE. No `data_valid`.
  - Match → STOP.
- STOP:
  - Sampled value 0 → `frame_error` = 1 for exactly 1 cycle at edge prescale-1, then IDLE. No `data_valid`.
  - Sampled value 1 → DATA_VALID at the edge-(prescale-1) transition.
- DATA_VALID:
  - Lasts one cycle: `data_valid` = 1 (Moore output) and `parallel_data` is loaded from the shift register.
  - Next state: IDLE, or START if the line is already 0.
- Latency: `data_valid` goes high on the first clk edge after the final edge of the stop bit, i.e. (bits_in_frame × prescale) cycles after start detection.
  - bits_in_frame = DATA_WIDTH + 2 + `parity_enable`.
- `parallel_data` holds its value until the next good frame. Errored frames never change it.
- Error pulses always return to 0 the following cycle.
- A line held low after an errored frame is treated as a new start.

Test Plan:
- Prescale 8, `parity_enable` = 1, even parity, byte 0x6A, parity bit 0, stop 1 → one cycle after the stop bit ends, `data_valid` = 1 and `parallel_data` = 0x6A; no error pulses.
- Prescale 8, `parity_enable` = 0, byte 0xA5 then 0x5A, with 4 idle cycles between frames → each frame gives `data_valid` = 1 with the matching byte.
- Prescale 8, odd parity, byte 0xF7, parity bit 0 → `data_valid` = 1, `parallel_data` = 0xF7.
- Start bit low for 1 clk, then line high → `frame_error` pulses 1 cycle and is 0 two cycles later; no `data_valid`.
- Odd parity, byte 0x57, wrong parity bit 1 → `parity_error` pulses 1 cycle and is 0 two cycles later; `parallel_data` unchanged.
- Byte 0x88, `parity_enable` = 0, stop bit 0 → `frame_error` pulses 1 cycle; `data_valid` stays 0.
- Assert `reset` mid-DATA → outputs 0 immediately; a following good frame is received correctly.
